// File: rtl/vgpr_rd_pkg.sv
// Shared types and constants for the VGPR read-port arbiter slice.
// Latency: none (declarations only).
// Backpressure: n/a.
package vgpr_rd_pkg;

    localparam int VGPR_ADDR_W = 10;

    localparam logic CLIENT_SIMD = 1'b0;
    localparam logic CLIENT_LSU  = 1'b1;

    // One in-flight read: which client it belongs to, and whether the slot is live.
    typedef struct packed {
        logic valid;
        logic client_id;
    } tag_t;

endpackage

// File: rtl/vgpr_rd_port_arbiter_if.sv
// Bundle of request, mux-port and response signals around the VGPR read arbiter.
// Latency: none (wiring only).
// Backpressure: reqN_ready only; responses cannot be stalled.
interface vgpr_rd_port_arbiter_if #(
    parameter int DATAWIDTH = 2048
);
    import vgpr_rd_pkg::*;

    logic                   req0_valid;
    logic [VGPR_ADDR_W-1:0] req0_addr;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [VGPR_ADDR_W-1:0] req1_addr;
    logic                   req1_ready;
    logic                   port0_rd_en;
    logic [VGPR_ADDR_W-1:0] port0_rd_addr;
    logic                   port1_rd_en;
    logic [VGPR_ADDR_W-1:0] port1_rd_addr;
    logic [DATAWIDTH-1:0]   port_rd_data;
    logic                   rsp0_valid;
    logic                   rsp1_valid;
    logic [DATAWIDTH-1:0]   rsp_data;

    // Clients plus read mux: drive requests and returned data.
    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, port_rd_data,
        input  req0_ready, req1_ready, port0_rd_en, port0_rd_addr,
               port1_rd_en, port1_rd_addr, rsp0_valid, rsp1_valid, rsp_data
    );

    // The arbiter itself.
    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, port_rd_data,
        output req0_ready, req1_ready, port0_rd_en, port0_rd_addr,
               port1_rd_en, port1_rd_addr, rsp0_valid, rsp1_valid, rsp_data
    );

endinterface

// File: rtl/vgpr_rd_tag_pipe.sv
// Delay line carrying {valid, client_id} alongside each outstanding VGPR read.
// Latency: RD_LATENCY cycles from tag_in to tag_out.
// Backpressure: none; shifts every cycle.
module vgpr_rd_tag_pipe
    import vgpr_rd_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t [RD_LATENCY-1:0] stage_q;

    // Shift register; reset discards every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/vgpr_rd_port_arbiter.sv
// Two-client VGPR read arbiter: 1-entry hold per client, one read issued per cycle.
// Latency: accept->issue 1 cycle, issue->rspN_valid RD_LATENCY+1 cycles.
// Backpressure: reqN_ready from hold state only; responses never stall.
// Option: VGPR_RD_ARB_FIXED_PRIO_EN makes client0 win every tie (client1 may starve).
module vgpr_rd_port_arbiter
    import vgpr_rd_pkg::*;
#(
    parameter int DATAWIDTH  = 2048,
    parameter int RD_LATENCY = 1
) (
    input logic                   clk,
    input logic                   rst,
    vgpr_rd_port_arbiter_if.slave bus
);

    logic                   hold0_valid;
    logic                   hold1_valid;
    logic [VGPR_ADDR_W-1:0] hold0_addr;
    logic [VGPR_ADDR_W-1:0] hold1_addr;
    logic                   grant0;
    logic                   grant1;
    logic                   ready0;
    logic                   ready1;
    tag_t                   issue_tag;
    tag_t                   done_tag;
    logic                   rsp0_valid_q;
    logic                   rsp1_valid_q;
    logic [DATAWIDTH-1:0]   rsp_data_q;

`ifndef VGPR_RD_ARB_FIXED_PRIO_EN
    logic                   last_grant;
`endif

    // Pick at most one hold to issue, using only registered state.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef VGPR_RD_ARB_FIXED_PRIO_EN
        grant0 = hold0_valid;
        grant1 = hold1_valid & ~hold0_valid;
`else
        if (hold0_valid && hold1_valid) begin
            grant0 = (last_grant == CLIENT_LSU);
            grant1 = (last_grant == CLIENT_SIMD);
        end else begin
            grant0 = hold0_valid;
            grant1 = hold1_valid;
        end
`endif
    end

    // A hold being drained this cycle can take a new request at the same edge.
    assign ready0 = ~hold0_valid | grant0;
    assign ready1 = ~hold1_valid | grant1;

    assign bus.req0_ready    = ready0;
    assign bus.req1_ready    = ready1;
    assign bus.port0_rd_en   = grant0;
    assign bus.port1_rd_en   = grant1;
    assign bus.port0_rd_addr = grant0 ? hold0_addr : '0;
    assign bus.port1_rd_addr = grant1 ? hold1_addr : '0;

    assign issue_tag.valid     = grant0 | grant1;
    assign issue_tag.client_id = grant1 ? CLIENT_LSU : CLIENT_SIMD;

    // Hold registers: load on accept, otherwise free once granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold0_valid <= 1'b0;
            hold1_valid <= 1'b0;
            hold0_addr  <= '0;
            hold1_addr  <= '0;
        end else begin
            if (bus.req0_valid && ready0) begin
                hold0_valid <= 1'b1;
                hold0_addr  <= bus.req0_addr;
            end else if (grant0) begin
                hold0_valid <= 1'b0;
            end
            if (bus.req1_valid && ready1) begin
                hold1_valid <= 1'b1;
                hold1_addr  <= bus.req1_addr;
            end else if (grant1) begin
                hold1_valid <= 1'b0;
            end
        end
    end

`ifndef VGPR_RD_ARB_FIXED_PRIO_EN
    // Remember the last winner; reset value lets client0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= CLIENT_LSU;
        end else if (grant0) begin
            last_grant <= CLIENT_SIMD;
        end else if (grant1) begin
            last_grant <= CLIENT_LSU;
        end
    end
`endif

    vgpr_rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (issue_tag),
        .tag_out (done_tag)
    );

    // Capture mux data when its tag emerges and strobe the owning client.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            rsp0_valid_q <= done_tag.valid & (done_tag.client_id == CLIENT_SIMD);
            rsp1_valid_q <= done_tag.valid & (done_tag.client_id == CLIENT_LSU);
            if (done_tag.valid) begin
                rsp_data_q <= bus.port_rd_data;
            end
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_vgpr_rd_port_arbiter.sv
// Directed bench for vgpr_rd_port_arbiter with a 1-cycle read mux model.
// Latency: mux returns data for a read one cycle after its rd_en.
// Backpressure: bench always sinks responses.
module tb_vgpr_rd_port_arbiter;

    localparam int DW = 2048;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vgpr_rd_port_arbiter_if #(.DATAWIDTH(DW)) bus ();

    vgpr_rd_port_arbiter #(
        .DATAWIDTH  (DW),
        .RD_LATENCY (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data encodes address and port so rsp_data identifies the read it came from.
    function automatic logic [DW-1:0] pat(input logic [9:0] a, input logic c);
        return {64{{21'h0, c, a}}};
    endfunction

    // VGPR mux model: data for a read appears the cycle after its enable.
    always @(posedge clk) begin
        if (bus.port0_rd_en)      bus.port_rd_data <= pat(bus.port0_rd_addr, 1'b0);
        else if (bus.port1_rd_en) bus.port_rd_data <= pat(bus.port1_rd_addr, 1'b1);
        else                      bus.port_rd_data <= '0;
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 10'h123;
        bus.req1_valid = 1'b1; bus.req1_addr = 10'h321;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.port0_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en0 got %b exp 0", bus.port0_rd_en); end
            checks++; if (bus.port1_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en1 got %b exp 0", bus.port1_rd_en); end
            checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", bus.req0_ready); end
            checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b exp 1", bus.req1_ready); end
            checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp got %b%b exp 00", bus.rsp0_valid, bus.rsp1_valid); end
            checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got low32 %h exp 0", bus.rsp_data[31:0]); end
            checks++; if (bus.port0_rd_addr !== 10'h0) begin errors++; $display("FAIL reset_addr0 got %h exp 0", bus.port0_rd_addr); end
        end
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 10'h005;
        @(negedge clk); // issue cycle T
        checks++; if (bus.port0_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en0 got %b exp 1", bus.port0_rd_en); end
        checks++; if (bus.port0_rd_addr !== 10'h005) begin errors++; $display("FAIL single_addr0 got %h exp 005", bus.port0_rd_addr); end
        checks++; if (bus.port1_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en1 got %b exp 0", bus.port1_rd_en); end
        bus.req0_valid = 1'b0;
        @(negedge clk); // T+1
        checks++; if (bus.port0_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en0_off got %b exp 0", bus.port0_rd_en); end
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp0_early got %b exp 0", bus.rsp0_valid); end
        @(negedge clk); // T+2
        checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("FAIL single_rsp0 got %b exp 1", bus.rsp0_valid); end
        checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1 got %b exp 0", bus.rsp1_valid); end
        checks++; if (bus.rsp_data !== pat(10'h005, 1'b0)) begin errors++; $display("FAIL single_data got low32 %h exp %h", bus.rsp_data[31:0], 32'h0000_0005); end
        @(negedge clk); // T+3
        checks++; if (bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_rsp0_one_shot got %b exp 0", bus.rsp0_valid); end
        checks++; if (bus.rsp_data !== pat(10'h005, 1'b0)) begin errors++; $display("FAIL single_data_hold got low32 %h exp %h", bus.rsp_data[31:0], 32'h0000_0005); end
    endtask

    task automatic test_round_robin();
        logic e0;
        logic [9:0] ea;
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 10'h010;
        bus.req1_valid = 1'b1; bus.req1_addr = 10'h3FF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e0 = (k % 2 == 0);
            checks++; if (bus.port0_rd_en !== e0) begin errors++; $display("FAIL rr_rd_en0 k=%0d got %b exp %b", k, bus.port0_rd_en, e0); end
            checks++; if (bus.port1_rd_en !== !e0) begin errors++; $display("FAIL rr_rd_en1 k=%0d got %b exp %b", k, bus.port1_rd_en, !e0); end
            checks++; if ((bus.port0_rd_en & bus.port1_rd_en) !== 1'b0) begin errors++; $display("FAIL rr_both_en k=%0d got 1 exp 0", k); end
            checks++; if (bus.req0_ready !== e0 || bus.req1_ready !== !e0) begin errors++; $display("FAIL rr_ready k=%0d got %b%b exp %b%b", k, bus.req0_ready, bus.req1_ready, e0, !e0); end
            ea = e0 ? 10'h010 : 10'h3FF;
            checks++; if ((e0 ? bus.port0_rd_addr : bus.port1_rd_addr) !== ea) begin errors++; $display("FAIL rr_addr k=%0d exp %h", k, ea); end
            if (k >= 2) begin
                checks++; if (bus.rsp0_valid !== e0 || bus.rsp1_valid !== !e0) begin errors++; $display("FAIL rr_rsp k=%0d got %b%b exp %b%b", k, bus.rsp0_valid, bus.rsp1_valid, e0, !e0); end
                checks++; if (bus.rsp_data !== pat(ea, !e0)) begin errors++; $display("FAIL rr_data k=%0d got low32 %h exp %h", k, bus.rsp_data[31:0], {21'h0, !e0, ea}); end
            end else begin
                checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rr_rsp_early k=%0d got %b%b exp 00", k, bus.rsp0_valid, bus.rsp1_valid); end
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_fixed_prio();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 10'h010;
        bus.req1_valid = 1'b1; bus.req1_addr = 10'h3FF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++; if (bus.port0_rd_en !== 1'b1 || bus.port1_rd_en !== 1'b0) begin errors++; $display("FAIL fp_grant k=%0d got %b%b exp 10", k, bus.port0_rd_en, bus.port1_rd_en); end
            checks++; if (bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL fp_rsp1 k=%0d got %b exp 0", k, bus.rsp1_valid); end
            if (k >= 2) begin
                checks++; if (bus.rsp0_valid !== 1'b1) begin errors++; $display("FAIL fp_rsp0 k=%0d got %b exp 1", k, bus.rsp0_valid); end
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        logic [9:0] ea;
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_addr = 10'h100;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (bus.rsp1_valid === 1'b1) strobes++;
            checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 k=%0d got %b exp 1", k, bus.req1_ready); end
            checks++; if (bus.port1_rd_en !== (k < 8)) begin errors++; $display("FAIL b2b_rd_en1 k=%0d got %b exp %b", k, bus.port1_rd_en, (k < 8)); end
            checks++; if (bus.port0_rd_en !== 1'b0 || bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL b2b_client0_idle k=%0d got %b%b exp 00", k, bus.port0_rd_en, bus.rsp0_valid); end
            if (k < 8) begin
                ea = 10'h100 + 10'(k);
                checks++; if (bus.port1_rd_addr !== ea) begin errors++; $display("FAIL b2b_addr k=%0d got %h exp %h", k, bus.port1_rd_addr, ea); end
            end
            if (k >= 2 && k <= 9) begin
                ea = 10'h100 + 10'(k - 2);
                checks++; if (bus.rsp_data !== pat(ea, 1'b1)) begin errors++; $display("FAIL b2b_data k=%0d got low32 %h exp %h", k, bus.rsp_data[31:0], {21'h0, 1'b1, ea}); end
            end
            if (k < 7) bus.req1_addr = 10'h100 + 10'(k + 1);
            else       bus.req1_valid = 1'b0;
        end
        checks++; if (strobes != 8) begin errors++; $display("FAIL b2b_strobes got %0d exp 8", strobes); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_addr = 10'h055;
        @(negedge clk); // T: client0 issues
        checks++; if (bus.port0_rd_en !== 1'b1) begin errors++; $display("FAIL rmid_rd_en0 got %b exp 1", bus.port0_rd_en); end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 10'h2AA;
        @(negedge clk); // T+1: client1 issues, reset sampled at end of this cycle
        checks++; if (bus.port1_rd_en !== 1'b1) begin errors++; $display("FAIL rmid_rd_en1 got %b exp 1", bus.port1_rd_en); end
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 10'h077;
        rst = 1'b1;
        @(negedge clk); // T+2
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_t2 got %b%b exp 00", bus.rsp0_valid, bus.rsp1_valid); end
        checks++; if (bus.port0_rd_en !== 1'b0 || bus.port1_rd_en !== 1'b0) begin errors++; $display("FAIL rmid_hold_dropped got %b%b exp 00", bus.port0_rd_en, bus.port1_rd_en); end
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b%b exp 11", bus.req0_ready, bus.req1_ready); end
        @(negedge clk); // T+3
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin errors++; $display("FAIL rmid_rsp_t3 got %b%b exp 00", bus.rsp0_valid, bus.rsp1_valid); end
        checks++; if (bus.rsp_data !== '0) begin errors++; $display("FAIL rmid_rsp_data got low32 %h exp 0", bus.rsp_data[31:0]); end
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef VGPR_RD_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
